// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the instruction ROM one word per cycle into a
// 2-entry queue and presents the head instruction to decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        misalign_err
);

  logic [31:0] pc_r;
  logic [31:0] q_inst_r [2];
  logic [31:0] q_pc_r   [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic        misalign_r;

  logic        fetch_s;
  logic        pop_s;

  // Fetch never looks at id_ready, so there is no decode-to-ROM timing path.
  assign fetch_s = rst_n & ~redirect_valid & (count_r != 2'd2);
  assign pop_s   = (count_r != 2'd0) & id_ready;

  // Output decode from registered state.
  always_comb begin
    rom_ce       = fetch_s;
    rom_addr     = {2'b00, pc_r[31:2]};
    id_valid     = (count_r != 2'd0);
    misalign_err = misalign_r;
    id_inst      = NOP_INST;
    id_pc        = 32'h0000_0000;
    if (count_r != 2'd0) begin
      id_inst = q_inst_r[rd_ptr_r];
      id_pc   = q_pc_r[rd_ptr_r];
    end else begin
      id_inst = NOP_INST;
      id_pc   = 32'h0000_0000;
    end
  end

  // Queue payload storage; written only on a real fetch.
  always_ff @(posedge clk) begin
    if (fetch_s) begin
      q_inst_r[wr_ptr_r] <= rom_inst;
      q_pc_r[wr_ptr_r]   <= pc_r;
    end else begin
      q_inst_r[wr_ptr_r] <= q_inst_r[wr_ptr_r];
      q_pc_r[wr_ptr_r]   <= q_pc_r[wr_ptr_r];
    end
  end

  // PC, queue pointers/occupancy and the sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      misalign_r <= 1'b0;
    end else if (redirect_valid) begin
      // A concurrent decode handshake is consumed; the flush drops everything else.
      pc_r     <= {redirect_pc[31:2], 2'b00};
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_r <= 1'b1;
      end else begin
        misalign_r <= misalign_r;
      end
    end else begin
      if (fetch_s) begin
        pc_r     <= pc_r + 32'd4;
        wr_ptr_r <= ~wr_ptr_r;
      end else begin
        pc_r     <= pc_r;
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({fetch_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; the ROM model returns
// 32'h1000_0000 + word index.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        misalign_err;

  int checks_s;
  int failures_s;

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .misalign_err   (misalign_err)
  );

  assign rom_inst = 32'h1000_0000 + rom_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_s++;
    if (act !== exp) begin
      failures_s++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge; this settles then checks.
  task automatic settle();
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
    chk({tag, "_inst"}, id_inst, inst);
    chk({tag, "_pc"}, id_pc, pc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    next_cycle();
    next_cycle();
    chk("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
  endtask

  initial begin
    checks_s = 0;
    failures_s = 0;
    rst_n = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    @(posedge clk);
    #1;

    // Reset release, free-running decode
    do_reset();
    rst_n = 1'b1;
    settle();
    chk("start_rom_ce", {31'd0, rom_ce}, 32'd1);
    chk("start_rom_addr", rom_addr, 32'd0);
    chk("start_id_valid", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      chk_head("stream", 32'h1000_0000 + 32'(k), 32'(4 * k));
      chk("stream_rom_addr", rom_addr, 32'(k + 1));
    end

    // Decode stall fills the queue, then drains without a bubble
    do_reset();
    id_ready = 1'b0;
    rst_n = 1'b1;
    settle();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      chk_head("stall", 32'h1000_0000, 32'd0);
    end
    chk("stall_rom_ce", {31'd0, rom_ce}, 32'd0);
    chk("stall_rom_addr", rom_addr, 32'd2);
    id_ready = 1'b1;
    settle();
    chk_head("drain0", 32'h1000_0000, 32'd0);
    chk("drain0_rom_ce", {31'd0, rom_ce}, 32'd0);
    next_cycle();
    chk_head("drain1", 32'h1000_0001, 32'd4);
    chk("drain1_rom_addr", rom_addr, 32'd2);
    next_cycle();
    chk_head("drain2", 32'h1000_0002, 32'd8);

    // Aligned redirect during steady fetch
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    settle();
    chk("redir_rom_ce", {31'd0, rom_ce}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("redir_bubble", {31'd0, id_valid}, 32'd0);
    chk("redir_rom_ce1", {31'd0, rom_ce}, 32'd1);
    chk("redir_rom_addr", rom_addr, 32'h0000_0010);
    next_cycle();
    chk_head("redir_t", 32'h1000_0010, 32'h0000_0040);
    next_cycle();
    chk_head("redir_t4", 32'h1000_0011, 32'h0000_0044);

    // Back-to-back redirects: only the last one sticks
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    next_cycle();
    redirect_pc = 32'h0000_0100;
    settle();
    chk("b2b_valid", {31'd0, id_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("b2b_rom_addr", rom_addr, 32'h0000_0040);
    next_cycle();
    chk_head("b2b", 32'h1000_0040, 32'h0000_0100);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0042;
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("mis_flag", {31'd0, misalign_err}, 32'd1);
    chk("mis_rom_addr", rom_addr, 32'h0000_0010);
    next_cycle();
    chk_head("mis", 32'h1000_0010, 32'h0000_0040);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Fill the queue, then reset together with a redirect
    id_ready = 1'b0;
    next_cycle();
    chk("full_rom_ce", {31'd0, rom_ce}, 32'd0);
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    next_cycle();
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_inst", id_inst, 32'h0000_0013);
    chk("mrst_rom_ce", {31'd0, rom_ce}, 32'd0);
    chk("mrst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("mrst_rom_addr", rom_addr, 32'd0);
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    settle();
    chk("mrst_restart_ce", {31'd0, rom_ce}, 32'd1);
    next_cycle();
    chk_head("mrst_restart", 32'h1000_0000, 32'd0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("wrap_addr0", rom_addr, 32'h3FFF_FFFE);
    next_cycle();
    chk_head("wrap0", 32'h4FFF_FFFE, 32'hFFFF_FFF8);
    chk("wrap_addr1", rom_addr, 32'h3FFF_FFFF);
    next_cycle();
    chk_head("wrap1", 32'h4FFF_FFFF, 32'hFFFF_FFFC);
    chk("wrap_addr2", rom_addr, 32'd0);
    next_cycle();
    chk_head("wrap2", 32'h1000_0000, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator that drives the instruction ROM's `ce`/word-address port and consumes its combinational `inst` return. It holds the PC, fetches one word per cycle into a 2-entry instruction queue, and presents instructions to the decode stage over a valid/ready handshake. It sits between the PC/branch logic of EX and the IF/ID boundary, and handles decode stalls and branch/jump redirects with queue flush.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset; must be word-aligned.
- `NOP_INST`, default 32'h0000_0013: value driven on `id_inst` when the queue is empty.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `rom_ce`, output, 1: ROM chip enable; 1 = fetch this cycle.
- `rom_addr`, output, 32: ROM word index, equal to {2'b00, pc[31:2]}.
- `rom_inst`, input, 32: ROM data; combinational, and valid in the same cycle as `rom_addr` when `rom_ce`=1.
- `redirect_valid`, input, 1: branch/jump taken; flush and restart at `redirect_pc`.
- `redirect_pc`, input, 32: redirect target byte address.
- `id_ready`, input, 1: decode accepts the head instruction this cycle.
- `id_valid`, output, 1: head instruction valid.
- `id_inst`, output, 32: head instruction word.
- `id_pc`, output, 32: byte address of the head instruction.
- `misalign_err`, output, 1: sticky flag; a redirect target had `redirect_pc[1:0]` != 0.

## Operation
- State consists of:
  - `pc` (32 b).
  - A 2-entry queue of {inst, pc} with read pointer, write pointer and `count` (0..2).
  - `misalign_err`.
- `rom_ce` = `rst_n` & ~`redirect_valid` & (`count` != 2). It depends only on registered state and `redirect_valid`. There is no path from `id_ready` to `rom_ce`.
- Fetch: when `rom_ce`=1, enqueue {`rom_inst`, `pc`} at the edge and advance `pc` to `pc`+4. `pc` wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Dequeue: when `id_valid` & `id_ready`, pop the head.
- Enqueue and dequeue in the same cycle leave `count` unchanged.
- `id_valid` = (`count` != 0).
- `id_inst` and `id_pc` show the head entry. When the queue is empty they show `NOP_INST` and 0.
- Stall: while `id_valid`=1 and `id_ready`=0, `id_inst` and `id_pc` hold stable. Fetching continues until `count`=2, then `rom_ce`=0 and `pc` holds.
- Redirect (highest priority): when `redirect_valid`=1:
  - Clear the queue (`count`=0, pointers 0).
  - Set `pc` <= {`redirect_pc`[31:2], 2'b00].
  - No enqueue occurs that cycle.
  - A simultaneous `id_ready` handshake still counts as consumed by decode; the flush discards the rest.
  - If `redirect_pc[1:0]` != 0, set `misalign_err`. It is cleared only by reset.
- Back-to-back redirects: only the last one takes effect. Each asserted cycle reloads `pc` and keeps the queue empty.

## Timing
- Reset (`rst_n`=0 at an edge) gives:
  - `pc`=`RESET_PC`, `count`=0, `misalign_err`=0.
  - Outputs during reset: `rom_ce`=0, `id_valid`=0, `id_inst`=`NOP_INST`, `id_pc`=0, `rom_addr`={2'b00, `RESET_PC`[31:2]}.
- Reset mid-operation discards queue contents and any pending redirect.
- Startup: in the first cycle with `rst_n`=1, `rom_ce`=1 and `rom_addr`=`RESET_PC`>>2. In the next cycle, `id_valid`=1 and `id_pc`=`RESET_PC`.
- Fetch latency is 1 cycle from `rom_addr` to `id_valid`.
- Steady state with `id_ready`=1 is 1 instruction per cycle with `count`=1.
- Redirect latency: `redirect_valid` in cycle N gives:
  - Cycle N+1: `rom_ce`=1, `rom_addr`=target>>2.
  - Cycle N+2: `id_valid`=1, `id_pc`=target.
  - `id_valid`=0 in cycle N+1, a 1-cycle bubble.
- Stall release: the cycle after `id_ready` returns to 1, the next queued entry appears with no bubble.

## Test plan
- Reset release with `RESET_PC`=0, ROM word k = 32'h1000_0000+k, `id_ready`=1 → `rom_addr` 0,1,2,…. `id_valid` rises one cycle after release. `id_inst`/`id_pc` sequence: (10000000,0), (10000001,4), (10000002,8).
- Hold `id_ready`=0 for 5 cycles after the first valid → `id_inst`=10000000 stable. `rom_ce` deasserts after `count` reaches 2 and `pc` holds at 8. On release, 10000000 and 10000001 drain back-to-back, then 10000002 follows without a bubble.
- Redirect to 32'h40 during steady fetch → queue flushed. One-cycle `id_valid`=0, then `id_pc`=0x40 with `id_inst`=10000010. No stale pre-redirect instruction reaches decode.
- Redirect to 32'h42 → `misalign_err`=1 and stays 1. Fetch resumes at `id_pc`=0x40. The next reset clears `misalign_err`.
- `rst_n`=0 while the queue is full and `redirect_valid`=1 → next cycle `id_valid`=0, `id_inst`=32'h13, `rom_ce`=0. After release, fetch restarts at `RESET_PC`.
- Set `pc` near the top via redirect to 32'hFFFF_FFF8 → consecutive `id_pc` values are FFFF_FFF8, FFFF_FFFC, 0000_0000. `rom_addr` wraps 3FFF_FFFE, 3FFF_FFFF, 0.
